// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and response record for the instruction fetch responder
package imem_pkg;
   localparam logic [31:0] IMEM_BASE_ADDR   = 32'h0100_0000;
   localparam int          IMEM_DEPTH_WORDS = 512;
   localparam logic [31:0] RV_NOP           = 32'h0000_0013;
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] addr;
      logic        err;
   } imem_rsp_t;
endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: synchronous response FIFO; flush wins over pop, a push in the flush cycle is kept
module imem_rsp_fifo
   import imem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  logic      flush,
   input  imem_rsp_t wr,
   output imem_rsp_t rd,
   output logic      empty,
   output logic      full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   imem_rsp_t     buffer [DEPTH];
   logic [PW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic          do_push, do_pop;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
   endfunction
   assign empty   = cnt == '0;
   assign full    = cnt == CW'(DEPTH);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd      = empty ? '0 : buffer[rp];
   always_ff @(posedge clk)
      if (do_push) buffer[flush ? '0 : wp] <= wr;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= PW'(do_push);
         rp  <= '0;
         cnt <= CW'(do_push);
      end else begin
         if (do_push) wp <= inc(wp);
         if (do_pop) rp <= inc(rp);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: in-order instruction fetch responder over a word RAM with a program-load port.
// IMEM_ERR_RESP_EN: range/alignment-checked requests answer rsp_err=1 with a NOP instead of wrapping.
module imem_fetch_responder
   import imem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = IMEM_BASE_ADDR,
   parameter int          DEPTH_WORDS = IMEM_DEPTH_WORDS,
   parameter int          LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [31:0] rsp_addr,
   output logic        rsp_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 2);
   logic [31:0]   mem [DEPTH_WORDS];
   logic [CW-1:0] outstanding;
   logic [31:0]   ld_off;
   logic          accept, pop, ld_ok, push_v, empty, full;
   imem_rsp_t     s_d, push_d, head;
   assign accept    = req_valid & req_ready;
   assign req_ready = outstanding < CW'(LATENCY + 1);
   assign pop       = rsp_valid & rsp_ready;
   assign ld_off    = ld_addr - BASE_ADDR;
   assign ld_ok     = ld_en & (ld_off < 32'(4 * DEPTH_WORDS)) & (ld_off[1:0] == 2'b00);
`ifdef IMEM_ERR_RESP_EN
   logic [31:0] off;
   logic        err;
   assign off = req_addr - BASE_ADDR;
   assign err = (off >= 32'(4 * DEPTH_WORDS)) | (off[1:0] != 2'b00);
   assign s_d = '{data: err ? RV_NOP : mem[off[AW+1:2]], addr: req_addr, err: err};
`else
   assign s_d = '{data: mem[AW'((req_addr - BASE_ADDR) >> 2)], addr: req_addr, err: 1'b0};
`endif
   always_ff @(posedge clk)
      if (ld_ok) mem[ld_off[AW+1:2]] <= ld_data;
   // The FIFO write is the last read stage, so only LATENCY-1 registers sit in front of it.
   generate
      if (LATENCY == 1) begin : g_direct
         assign push_v = accept;
         assign push_d = s_d;
      end else begin : g_pipe
         logic      v [LATENCY-1];
         imem_rsp_t d [LATENCY-1];
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               for (int i = 0; i < LATENCY - 1; i++) v[i] <= 1'b0;
            end else begin
               v[0] <= accept;
               for (int i = 1; i < LATENCY - 1; i++) v[i] <= v[i-1] & ~flush;
            end
         always_ff @(posedge clk) begin
            d[0] <= s_d;
            for (int i = 1; i < LATENCY - 1; i++) d[i] <= d[i-1];
         end
         assign push_v = v[LATENCY-2] & ~flush;
         assign push_d = d[LATENCY-2];
      end
   endgenerate
   imem_rsp_fifo #(.DEPTH(LATENCY + 1)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_v & ~full),
      .pop   (pop),
      .flush (flush),
      .wr    (push_d),
      .rd    (head),
      .empty (empty),
      .full  (full)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) outstanding <= '0;
      else outstanding <= flush ? CW'(accept) : outstanding + CW'(accept) - CW'(pop);
   assign rsp_valid = ~empty;
   assign rsp_data  = head.data;
   assign rsp_addr  = head.addr;
   assign rsp_err   = head.err;
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: directed self-checking bench for imem_fetch_responder at LATENCY=1
module tb_imem_fetch_responder;
   import imem_pkg::*;
   localparam logic [31:0] B = IMEM_BASE_ADDR;
   logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, flush = 1'b0, rsp_ready = 1'b0, ld_en = 1'b0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0, rsp_data, rsp_addr;
   logic [31:0] ea [3], ed [3];
   logic        ee;
   int          total = 0, bad = 0, acc;
   always #5 clk = ~clk;
   imem_fetch_responder #(.LATENCY(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );
   function automatic logic [31:0] wd(input int k);
      return k == 0 ? 32'h0050_0093 : 32'h1000_0000 + 32'(k);
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic chk_rsp(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_addr"}, rsp_addr, a);
      chk({tag, "_data"}, rsp_data, d);
      chk({tag, "_err"}, 32'(rsp_err), 32'(e));
   endtask
   initial begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", rsp_data, 32'd0);
      chk("rst_addr", rsp_addr, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         ld_en = 1'b1; ld_addr = B + 32'(4 * k); ld_data = wd(k);
      end
      @(negedge clk);
      ld_addr = B + 32'h800; ld_data = 32'hdead_0001;
      @(negedge clk);
      ld_addr = B + 32'h1; ld_data = 32'hdead_0002;
      @(negedge clk);
      ld_en = 1'b0;
      // single fetch: response visible one cycle after accept
      req_valid = 1'b1; req_addr = B; rsp_ready = 1'b1;
      chk("t1_pre_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_rsp("t1", B, wd(0), 1'b0);
      @(negedge clk);
      chk("t1_drained", 32'(rsp_valid), 32'd0);
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk_rsp("t2", B + 32'(4 * (i - 1)), wd(i - 1), 1'b0);
            chk("t2_ready", 32'(req_ready), 32'd1);
         end
         req_valid = i < 8; req_addr = B + 32'(4 * i);
      end
      @(negedge clk);
      chk("t2_drained", 32'(rsp_valid), 32'd0);
      // backpressure: exactly two accepted, head held
      rsp_ready = 1'b0; acc = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 3) chk("t3_head_early", rsp_addr, B + 32'h20);
         req_valid = 1'b1; req_addr = B + 32'h20 + 32'(4 * acc);
         if (req_ready) acc++;
      end
      @(negedge clk);
      chk("t3_accepted", 32'(acc), 32'd2);
      chk("t3_ready", 32'(req_ready), 32'd0);
      chk_rsp("t3_h0", B + 32'h20, wd(8), 1'b0);
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      chk_rsp("t3_h1", B + 32'h24, wd(9), 1'b0);
      @(negedge clk);
      chk("t3_drained", 32'(rsp_valid), 32'd0);
      // flush alone drops two buffered responses
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = B + 32'h4;
      @(negedge clk);
      req_addr = B + 32'h8;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b1;
      chk("t4_full_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      flush = 1'b0;
      chk("t4_flush_valid", 32'(rsp_valid), 32'd0);
      chk("t4_flush_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = B + 32'h4;
      @(negedge clk);
      flush = 1'b1; req_addr = B + 32'h40;
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      chk_rsp("t4_keep", B + 32'h40, wd(16), 1'b0);
      chk("t4_keep_ready", 32'(req_ready), 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_drained", 32'(rsp_valid), 32'd0);
`ifdef IMEM_ERR_RESP_EN
      ea = '{B + 32'h800, B + 32'h2, B - 32'h4};
      ed = '{RV_NOP, RV_NOP, RV_NOP};
      ee = 1'b1;
`else
      ea = '{B + 32'h800, B + 32'h6, B + 32'h808};
      ed = '{wd(0), wd(1), wd(2)};
      ee = 1'b0;
`endif
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i > 0) chk_rsp("t5_edge", ea[i-1], ed[i-1], ee);
         req_valid = i < 3; req_addr = i < 3 ? ea[i] : B;
      end
      // read and load of one word in one cycle return the old word
      @(negedge clk);
      req_valid = 1'b1; req_addr = B + 32'h8; ld_en = 1'b1; ld_addr = B + 32'h8; ld_data = 32'hcafe_f00d;
      @(negedge clk);
      ld_en = 1'b0;
      chk_rsp("rdw_old", B + 32'h8, wd(2), 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_rsp("rdw_new", B + 32'h8, 32'hcafe_f00d, 1'b0);
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = B;
      @(negedge clk);
      req_addr = B + 32'h4;
      @(negedge clk);
      req_valid = 1'b0;
      chk("t6_full_ready", 32'(req_ready), 32'd0);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
      chk("t6_rst_ready", 32'(req_ready), 32'd1);
      chk("t6_rst_data", rsp_data, 32'd0);
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b1; req_addr = B; rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk_rsp("t6_mem", B, wd(0), 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
